store_buffer_unit: RTL
======================

# store_buffer_unit

Parametrised store stage for the single-cycle MIPS datapath. It decodes `sb`/`sh`/`sw`, computes the effective address and byte-lane enables, and checks alignment. Accepted stores go into a DEPTH-entry FIFO that drains to data memory over a req/ack handshake. Optionally, a new store to the same word as the newest queued entry is merged into that entry. It sits between the register file/ALU and data memory.

## Interface
- DEPTH, 4: store-buffer entries; power of two, ≥2
- COALESCE, 1: 1 = merge same-word stores into the tail entry; 0 = never merge
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately
- instruction  input  32  {opcode[31:26], rs[25:21], rt[20:16], imm[15:0]}
- Read_data1  input  32  rs value (base)
- Read_data2  input  32  rt value (store data)
- valid_in  input  1  instruction/operands valid this cycle
- ready_in  output  1  buffer can accept a store; combinational: count != DEPTH
- mem_req  output  1  head entry valid; 1 whenever count != 0
- mem_ack  input  1  memory accepts the head entry this cycle
- address  output  32  head word address, {addr[31:2],2'b00}
- write_data  output  32  head lane-positioned data
- byte_en  output  4  head byte lanes; bit i = byte [8i+7:8i]
- write_enable  output  1  equal to mem_req
- misaligned  output  1  one-cycle pulse, registered: a store was dropped for alignment
- bad_addr  output  32  effective address of the last dropped store
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Store opcodes: sb = 6'b101000, sh = 6'b101001, sw = 6'b101011. Any other opcode with valid_in is ignored with no state change.
- Effective address: ea = Read_data1 + {{16{imm[15]}},imm}, modulo 2^32. Wrap-around is silent.
- Lanes:
  - sw: data = Read_data2, be = 4'b1111.
  - sh: data = {2{Read_data2[15:0]}}, be = ea[1] ? 4'b1100 : 4'b0011.
  - sb: data = {4{Read_data2[7:0]}}, be = 4'b0001 << ea[1:0].
- Alignment: sh with ea[0]=1, or sw with ea[1:0]≠0, is dropped. Next cycle: misaligned=1 and bad_addr=ea. A dropped store does not change FIFO state. Alignment is checked even when ready_in=0.
- Accept condition: valid_in && store opcode && aligned && ready_in.
- Coalesce (COALESCE=1): applies when the accept condition holds, count ≥ 2, and ea[31:2] equals the tail entry's word address.
  - The incoming store merges into the tail: for each set be bit, the tail byte takes the new data; tail be |= new be.
  - count is unchanged.
  - The head entry, which is exposed to memory, is never merged.
- Otherwise an accepted store is pushed at the tail.
- Retire: when mem_req && mem_ack, the head pops. mem_ack while empty is ignored.
- Simultaneous push and pop: both happen and count is unchanged. Simultaneous merge and pop: the merge applies to the tail, the head pops, and count decrements.
- Full: ready_in=0 and the store is not taken. A pop in the same cycle does not enable a push.
- Empty: address, write_data and byte_en are driven to 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, active-low):
  - count=0, pointers=0, mem_req=0, write_enable=0.
  - address, write_data and byte_en = 0.
  - misaligned=0, bad_addr=0.
  - Queued entries are discarded, including any head being presented mid-handshake.
- Latency: a store accepted at edge N into an empty buffer gives mem_req=1 after edge N, with its address/data/be valid in the same cycle.
- Head outputs stay stable while mem_req=1 and mem_ack=0. Memory may hold mem_ack low for any number of cycles.
- Throughput: one push and one pop per cycle.
- misaligned goes high for exactly the cycle after the offending store is presented. Back-to-back bad stores give consecutive pulses, and bad_addr updates each cycle.

## Test plan
- Reset then single sw: instruction=32'hAD090004, Read_data1=0, Read_data2=32'h12345678, mem_ack=0. Next cycle: mem_req=1, address=32'h4, write_data=32'h12345678, byte_en=4'b1111, count=1. Assert mem_ack for 1 cycle → count=0, mem_req=0.
- sb: base 32'h1C, imm 32'h21, rt=32'hABCDEF01, so ea=32'h3D. Required: address=32'h3C, write_data=32'h01010101, byte_en=4'b0010. sh at ea=32'h3E → byte_en=4'b1100, write_data={2{rt[15:0]}}.
- Misaligned: sw at ea=32'h22. Next cycle: misaligned=1, bad_addr=32'h22, count unchanged, then misaligned=0. sh at ea=32'h21 gives the same behaviour.
- Fill and backpressure: DEPTH=4, mem_ack=0, five sw to distinct words. Required: ready_in=0 after the 4th, 5th not stored, count=4. Assert mem_ack and the entries drain in order.
- Coalesce: mem_ack=0. Push sw 32'h11111111 @0x100, then sw 32'h22222222 @0x200, then sb 32'h000000AB @0x202. Required: count=2; entry 1 data=32'h22AB2222, be=4'b1111. With COALESCE=0: count=3.
- Reset mid-operation: 3 entries queued, mem_req=1. Drop reset low asynchronously between edges. Required: mem_req=0 and count=0 immediately; after release, a new store enters entry 0.

Source files
------------

// File: rtl/store_buffer_unit.sv
// Store stage: decodes sb/sh/sw, forms lane-positioned data and byte enables,
// drops misaligned stores, and queues accepted stores for a req/ack memory drain.
module store_buffer_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          COALESCE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instruction,
  input  logic [31:0]              Read_data1,
  input  logic [31:0]              Read_data2,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [31:0]              address,
  output logic [31:0]              write_data,
  output logic [3:0]               byte_en,
  output logic                     write_enable,
  output logic                     misaligned,
  output logic [31:0]              bad_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_TWO = 2;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  logic [5:0]    opcode;
  logic [31:0]   ea;
  logic          is_store;
  logic          aligned;
  logic [31:0]   new_data;
  logic [3:0]    new_be;
  logic          bad;
  logic          accept;
  logic          merge;
  logic          push;
  logic          pop;

  logic [29:0]   ent_word [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [3:0]    ent_be   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail_ptr;

  assign opcode = instruction[31:26];
  assign ea     = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};

  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b0;
    new_data = '0;
    new_be   = '0;
    case (opcode)
      OP_SB: begin
        is_store = 1'b1;
        aligned  = 1'b1;
        new_data = {4{Read_data2[7:0]}};
        new_be   = 4'b0001 << ea[1:0];
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~ea[0];
        new_data = {2{Read_data2[15:0]}};
        new_be   = ea[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        is_store = 1'b1;
        aligned  = (ea[1:0] == 2'b00);
        new_data = Read_data2;
        new_be   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign tail_ptr = wr_ptr - PTR_ONE;
  assign ready_in = (count != CNT_FULL);
  assign bad      = valid_in & is_store & ~aligned;
  assign accept   = valid_in & is_store & aligned & ready_in;
  // count >= 2 guarantees the tail is never the head currently offered to memory
  assign merge    = COALESCE && accept && (count >= CNT_TWO) &&
                    (ea[31:2] == ent_word[tail_ptr]);
  assign push     = accept & ~merge;
  assign pop      = mem_req & mem_ack;

  assign mem_req      = (count != '0);
  assign write_enable = mem_req;
  assign address      = mem_req ? {ent_word[rd_ptr], 2'b00} : '0;
  assign write_data   = mem_req ? ent_data[rd_ptr] : '0;
  assign byte_en      = mem_req ? ent_be[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
      bad_addr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_word[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      misaligned <= bad;
      if (bad) bad_addr <= ea;
      if (push) begin
        ent_word[wr_ptr] <= ea[31:2];
        ent_data[wr_ptr] <= new_data;
        ent_be[wr_ptr]   <= new_be;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (merge) begin
        for (int unsigned i = 0; i < 4; i++)
          if (new_be[i]) ent_data[tail_ptr][8*i +: 8] <= new_data[8*i +: 8];
        ent_be[tail_ptr] <= ent_be[tail_ptr] | new_be;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule
